mem_stage: RTL

- Memory stage of the pipeline; consumes the EX/MEM buffer produced by the execute stage.
- Runs data-memory loads and stores over a req/ack handshake with variable latency, and stalls upstream while an access is outstanding.
- Registers the MEM/WB buffer.
- Exposes the forwarding value, destination register and write flag that the hazard unit uses to generate Fa/Fb.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Pipeline memory stage: runs loads/stores over a req/ack handshake and registers MEM/WB.
// Optional access timeout with sticky memErr when MEM_TIMEOUT_EN is defined.
module mem_stage #(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [2*N+7:0]   exBuffer,
  output logic             stall,
  output logic             memReq,
  output logic             memWe,
  output logic [N-1:0]     memAddr,
  output logic [N-1:0]     memWData,
  input  logic             memAck,
  input  logic [N-1:0]     memRData,
  output logic [2*N+5:0]   wbBuffer,
  output logic [N-1:0]     fwdValue,
  output logic [3:0]       fwdRc,
  output logic             fwdRegWrite,
  output logic             memErr
);

  typedef enum logic [1:0] {READY, ACCESS, COMPLETE} state_t;

  state_t           state, state_n;
  logic             ex_regwrite, ex_memtoreg, ex_memwrite, ex_branchflag;
  logic [3:0]       ex_rc;
  logic [N-1:0]     ex_rd3, ex_aluout;
  logic             mem_op;

  logic [2*N+5:0]   wb_n;
  logic             req_n, we_n;
  logic [N-1:0]     addr_n, wdata_n;
  logic             op_regwrite, op_regwrite_n;
  logic             op_memtoreg, op_memtoreg_n;
  logic [3:0]       op_rc, op_rc_n;
  logic             killed, killed_n;
  logic             stall_raw;

  // branchFlag only matters upstream; regWrite already carries its effect here
  logic             unused_ok;

  assign {ex_regwrite, ex_memtoreg, ex_memwrite, ex_branchflag,
          ex_rc, ex_rd3, ex_aluout} = exBuffer;
  assign mem_op    = ex_memwrite | ex_memtoreg;
  assign unused_ok = ex_branchflag;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;
`else
  localparam int unused_timeout = TIMEOUT;
  assign memErr = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    wb_n          = wbBuffer;
    req_n         = memReq;
    we_n          = memWe;
    addr_n        = memAddr;
    wdata_n       = memWData;
    op_regwrite_n = op_regwrite;
    op_memtoreg_n = op_memtoreg;
    op_rc_n       = op_rc;
    killed_n      = killed;
    stall_raw     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_n         = cnt;
    err_n         = memErr;
`endif
    unique case (state)
      READY: begin
        if (flush) begin
          wb_n = '0;
        end else if (mem_op) begin
          stall_raw     = 1'b1;
          req_n         = 1'b1;
          we_n          = ex_memwrite;
          addr_n        = ex_aluout;
          wdata_n       = ex_rd3;
          op_regwrite_n = ex_regwrite;
          op_memtoreg_n = ex_memtoreg;
          op_rc_n       = ex_rc;
          wb_n          = '0;
          state_n       = ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_n         = '0;
`endif
        end else begin
          wb_n = {ex_regwrite, ex_memtoreg, ex_rc, {N{1'b0}}, ex_aluout};
        end
      end
      ACCESS: begin
        stall_raw = 1'b1;
        if (memAck) begin
          req_n   = 1'b0;
          state_n = COMPLETE;
          // Address/write-enable registers still hold the op's aluOut and memWrite
          if (killed || flush)
            wb_n = '0;
          else
            wb_n = {op_regwrite, op_memtoreg, op_rc,
                    memWe ? {N{1'b0}} : memRData, memAddr};
        end else begin
          if (flush)
            killed_n = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt == CW'(TIMEOUT - 1)) begin
            req_n   = 1'b0;
            err_n   = 1'b1;
            wb_n    = '0;
            state_n = COMPLETE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
`endif
        end
      end
      COMPLETE: begin
        wb_n     = '0;
        killed_n = 1'b0;
        state_n  = READY;
      end
      default: begin
        state_n = READY;
      end
    endcase
  end

  assign stall = stall_raw & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= READY;
      wbBuffer    <= '0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWData    <= '0;
      op_regwrite <= 1'b0;
      op_memtoreg <= 1'b0;
      op_rc       <= '0;
      killed      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
      memErr      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      wbBuffer    <= wb_n;
      memReq      <= req_n;
      memWe       <= we_n;
      memAddr     <= addr_n;
      memWData    <= wdata_n;
      op_regwrite <= op_regwrite_n;
      op_memtoreg <= op_memtoreg_n;
      op_rc       <= op_rc_n;
      killed      <= killed_n;
`ifdef MEM_TIMEOUT_EN
      cnt         <= cnt_n;
      memErr      <= err_n;
`endif
    end
  end

  assign fwdRegWrite = wbBuffer[2*N+5];
  assign fwdRc       = wbBuffer[2*N+3:2*N];
  assign fwdValue    = wbBuffer[2*N+4] ? wbBuffer[2*N-1:N] : wbBuffer[N-1:0];

endmodule
